// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter and receiver:
// FSM state encoding, parity modes, parameter range checks and the parity helper.
`define UART_IN_RANGE(val, lo, hi) (((val) >= (lo)) && ((val) <= (hi)))

package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Callers zero-extend the payload to 9 bits; padding zeros leave the XOR unchanged.
    function automatic logic calc_parity(input logic odd, input logic [8:0] data);
        calc_parity = (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit timer shared by the UART transmitter and receiver: counts baud ticks
// and flags the tick that completes the current bit.
module uart_bit_timer #(
    parameter int OVERSAMPLE = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic baud_tick,
    output logic bit_end
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);

    logic [TW-1:0] tick_cnt_r;

    assign bit_end = baud_tick && (tick_cnt_r == LAST_TICK);

    // Tick counter within the current bit; holds when no tick arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_r <= '0;
        end else if (clear || bit_end) begin
            tick_cnt_r <= '0;
        end else if (baud_tick) begin
            tick_cnt_r <= tick_cnt_r + TW'(1);
        end else begin
            tick_cnt_r <= tick_cnt_r;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB-first,
// optional parity bit and 1 or 2 stop bits, each bit OVERSAMPLE baud ticks long.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] din,
    output logic                 o_tx_busy,
    output logic                 o_tx_done,
    output logic                 o_tx
);

    if (!`UART_IN_RANGE(DATA_BITS, 5, 9) || !`UART_IN_RANGE(OVERSAMPLE, 2, 16) ||
        !`UART_IN_RANGE(PARITY, 0, 2) || !`UART_IN_RANGE(STOP_BITS, 1, 2)) begin : g_bad_param
        $error("uart_tx_cfg: illegal parameter combination");
    end

    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_t          state_r, state_n;
    logic [DATA_BITS-1:0] shreg_r, shreg_n;
    logic [BW-1:0]        bit_cnt_r, bit_cnt_n;
    logic                 stop_cnt_r, stop_cnt_n;
    logic                 par_r, par_n;
    logic                 tx_r, tx_n;
    logic                 busy_r, busy_n;
    logic                 done_r, done_n;
    logic                 bit_end_s;

    uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_bit_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (state_r == S_IDLE),
        .baud_tick (baud_tick),
        .bit_end   (bit_end_s)
    );

    // Next-state, datapath and line value for the following cycle.
    always_comb begin
        state_n    = state_r;
        shreg_n    = shreg_r;
        par_n      = par_r;
        bit_cnt_n  = bit_cnt_r;
        stop_cnt_n = stop_cnt_r;
        done_n     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_n = S_START;
                    shreg_n = din;
                    par_n   = calc_parity(PARITY == PAR_ODD, 9'(din));
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    state_n   = S_DATA;
                    bit_cnt_n = '0;
                end else begin
                    state_n = S_START;
                end
            end
            S_DATA: begin
                if (bit_end_s) begin
                    shreg_n = {1'b0, shreg_r[DATA_BITS-1:1]};
                    if (bit_cnt_r == LAST_BIT) begin
                        bit_cnt_n = '0;
                        if (PARITY != PAR_NONE) begin
                            state_n = S_PARITY;
                        end else begin
                            state_n = S_STOP;
                        end
                        stop_cnt_n = 1'b0;
                    end else begin
                        bit_cnt_n = bit_cnt_r + BW'(1);
                    end
                end else begin
                    state_n = S_DATA;
                end
            end
            S_PARITY: begin
                if (bit_end_s) begin
                    state_n    = S_STOP;
                    stop_cnt_n = 1'b0;
                end else begin
                    state_n = S_PARITY;
                end
            end
            S_STOP: begin
                if (bit_end_s) begin
                    if (stop_cnt_r == LAST_STOP) begin
                        state_n    = S_IDLE;
                        stop_cnt_n = 1'b0;
                        done_n     = 1'b1;
                    end else begin
                        stop_cnt_n = 1'b1;
                    end
                end else begin
                    state_n = S_STOP;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Line value is a function of the state being entered so o_tx stays a flop.
        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = shreg_n[0];
            S_PARITY: tx_n = par_n;
            default:  tx_n = 1'b1;
        endcase
        busy_n = (state_n != S_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            shreg_r    <= '0;
            par_r      <= 1'b0;
            bit_cnt_r  <= '0;
            stop_cnt_r <= 1'b0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_n;
            shreg_r    <= shreg_n;
            par_r      <= par_n;
            bit_cnt_r  <= bit_cnt_n;
            stop_cnt_r <= stop_cnt_n;
            tx_r       <= tx_n;
            busy_r     <= busy_n;
            done_r     <= done_n;
        end
    end

    assign o_tx      = tx_r;
    assign o_tx_busy = busy_r;
    assign o_tx_done = done_r;

endmodule
